// File: rtl/fc_stream_host.sv
// Stream host for one fc layer: sends an N-word vector on the master side,
// then captures M result words from the slave side into a readable buffer.
module fc_stream_host #(
    parameter int          WIDTH    = 16,
    parameter int          N        = 4,
    parameter int          M        = 8,
    parameter logic [7:0]  THROTTLE = 8'hFF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 vec_wr_en,
    input  logic [$clog2(N)-1:0] vec_wr_addr,
    input  logic [WIDTH-1:0]     vec_wr_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    input  logic [$clog2(M)-1:0] res_rd_addr,
    output logic [WIDTH-1:0]     res_rd_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WIDTH-1:0]     m_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WIDTH-1:0]     s_data
);
    localparam int NW = $clog2(N);
    localparam int MW = $clog2(M);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] SEND  = 3'd2;
    localparam logic [2:0] RECV  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]       state;
    logic [NW-1:0]    send_cnt;
    logic [NW-1:0]    send_nxt;
    logic [MW-1:0]    recv_cnt;
    logic [7:0]       pattern;
    logic [WIDTH-1:0] vec [N];
    logic [WIDTH-1:0] res [M];
    logic             m_fire;
    logic             s_fire;

    // Status and handshakes decode straight from registers, never from inputs.
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign s_ready  = (state == RECV) && pattern[0];
    assign m_fire   = m_valid && m_ready;
    assign s_fire   = s_valid && s_ready;
    assign send_nxt = send_cnt + NW'(1);

    // Run sequencing, send-side prefetch and receive throttle rotation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            send_cnt <= '0;
            recv_cnt <= '0;
            pattern  <= THROTTLE;
            m_valid  <= 1'b0;
            m_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FETCH;
                        send_cnt <= '0;
                        recv_cnt <= '0;
                    end
                end
                FETCH: begin
                    m_data  <= vec[0];
                    m_valid <= 1'b1;
                    state   <= SEND;
                end
                SEND: begin
                    if (m_fire) begin
                        if (send_cnt == NW'(N - 1)) begin
                            m_valid <= 1'b0;
                            state   <= RECV;
                        end else begin
                            send_cnt <= send_nxt;
                            m_data   <= vec[send_nxt];
                        end
                    end
                end
                RECV: begin
                    pattern <= {pattern[0], pattern[7:1]};
                    if (s_fire) begin
                        if (recv_cnt == MW'(M - 1)) begin
                            state <= DONE;
                        end else begin
                            recv_cnt <= recv_cnt + MW'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

    // Input vector is writable only between runs; contents survive reset.
    always_ff @(posedge clk) begin
        if (vec_wr_en && !busy) begin
            vec[vec_wr_addr] <= vec_wr_data;
        end
    end

    // Result capture; words already stored survive a mid-run reset.
    always_ff @(posedge clk) begin
        if (s_fire && !reset) begin
            res[recv_cnt] <= s_data;
        end
    end

    // Registered result read port, old data on a same-cycle write.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_rd_data <= '0;
        end else begin
            res_rd_data <= res[res_rd_addr];
        end
    end
endmodule
